// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, port ids and
// memory direction codes.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker. Purely combinational; the history bit (last)
// is owned by the caller so it can be reset and updated with the grant.
module rr_pick2
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // A tie goes to the port that did not win last time; otherwise the lone requester.
    always_comb begin
        valid = |req;
        gnt   = PORT_CPU;
        if (&req) begin
            gnt = ~last;
        end else if (req[PORT_LDR]) begin
            gnt = PORT_LDR;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single word-wide data memory between the CPU port (0) and the
// loader/debug port (1). One transaction every three cycles: IDLE grants,
// ACCESS drives the memory, RESP pulses ack (or err for a rejected address).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    // Highest word-aligned address whose four bytes all lie inside the memory.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a <= MAX_ADDR);
    endfunction

    arb_state_t        state, state_d;
    logic              rr_last;
    logic              pick_gnt, pick_vld;
    logic              sel_we, sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              start_access, start_reject;
    logic              we_q;

    rr_pick2 u_pick (
        .req   ({p1_req, p0_req}),
        .last  (rr_last),
        .gnt   (pick_gnt),
        .valid (pick_vld)
    );

    // Mux the winning requester's fields and classify its address.
    always_comb begin
        sel_we       = pick_gnt ? p1_we    : p0_we;
        sel_addr     = pick_gnt ? p1_addr  : p0_addr;
        sel_wdata    = pick_gnt ? p1_wdata : p0_wdata;
        sel_ok       = addr_ok(sel_addr);
        start_access = (state == ST_IDLE) && pick_vld && sel_ok;
        start_reject = (state == ST_IDLE) && pick_vld && !sel_ok;
    end

    // Next state: rejected requests skip the memory cycle and go straight to RESP.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (pick_vld) state_d = sel_ok ? ST_ACCESS : ST_RESP;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register and busy flag (busy mirrors "not IDLE" as a registered output).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != ST_IDLE);
        end
    end

    // Grant bookkeeping: round-robin history, owner id and the captured direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= PORT_LDR;
            gnt_id  <= PORT_CPU;
            we_q    <= 1'b0;
        end else if (state == ST_IDLE && pick_vld) begin
            rr_last <= pick_gnt;
            gnt_id  <= pick_gnt;
            we_q    <= sel_we;
        end
    end

    // Memory side: mem_addr/mem_wdata double as the captured request registers, so
    // they only load on an accepted grant and hold otherwise; mem_rw is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= MEM_RD;
        end else begin
            mem_rw <= MEM_RD;
            if (start_access) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_rw    <= sel_we ? MEM_WR : MEM_RD;
            end
        end
    end

    // Requester side: ack/err pulses for the owner, load data latched at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            if (state == ST_ACCESS) begin
                if (gnt_id == PORT_LDR) p1_ack <= 1'b1;
                else                    p0_ack <= 1'b1;
                if (!we_q) begin
                    if (gnt_id == PORT_LDR) p1_rdata <= mem_rdata;
                    else                    p0_rdata <= mem_rdata;
                end
            end
            if (start_reject) begin
                if (pick_gnt == PORT_LDR) p1_err <= 1'b1;
                else                      p0_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed transactions push expected responses and
// memory writes into queues; negedge monitors pop and compare.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_ack, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_ack, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rw, busy, gnt_id;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(21)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    // Memory model: combinational read, write on the falling edge.
    logic [31:0] mem_words [0:7];
    assign mem_rdata = (mem_addr < 32'd20) ? mem_words[mem_addr[4:2]] : 32'h0;
    always @(negedge clk) begin
        if (mem_rw && mem_addr < 32'd20) mem_words[mem_addr[4:2]] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          port;
        bit          err;
        bit          load;
        logic [31:0] rdata;
        int          when;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    resp_t e_r;
    wr_t   w_r;
    logic  got_port, got_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (p0_ack | p0_err | p1_ack | p1_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_resp: p0 ack/err=%b%b p1 ack/err=%b%b, expected none (cycle %0d)",
                         p0_ack, p0_err, p1_ack, p1_err, cyc);
            end else begin
                e_r      = exp_q.pop_front();
                got_port = p1_ack | p1_err;
                got_err  = p0_err | p1_err;
                check("resp_one_port", 32'((p0_ack | p0_err) & (p1_ack | p1_err)), 32'd0);
                check("resp_port", 32'(got_port), 32'(e_r.port));
                check("resp_err", 32'(got_err), 32'(e_r.err));
                check("resp_cycle", cyc, e_r.when);
                check("resp_busy", 32'(busy), 32'd1);
                check("resp_gnt_id", 32'(gnt_id), 32'(e_r.port));
                if (e_r.load) check("resp_rdata", got_port ? p1_rdata : p0_rdata, e_r.rdata);
            end
        end
    end

    // Memory write monitor.
    always @(negedge clk) begin
        if (mem_rw) begin
            if (wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                w_r = wr_q.pop_front();
                check("wr_addr", mem_addr, w_r.addr);
                check("wr_data", mem_wdata, w_r.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic set_req(input bit port, input bit req);
        if (port) p1_req = req;
        else      p0_req = req;
    endtask

    task automatic expect_resp(input bit port, input bit err, input bit load,
                               input logic [31:0] rdata, input int when);
        resp_t r;
        r.port = port; r.err = err; r.load = load; r.rdata = rdata; r.when = when;
        exp_q.push_back(r);
    endtask

    task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    // Single uncontested transaction; req drops in the cycle the response shows.
    task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata_exp, input bit ok);
        int k;
        k = cyc;
        if (ok) begin
            expect_resp(port, 1'b0, !we, rdata_exp, k + 2);
            if (we) expect_wr(addr, wdata);
        end else begin
            expect_resp(port, 1'b1, 1'b0, 32'h0, k + 1);
        end
        set_port(port, 1'b1, we, addr, wdata);
        tick(ok ? 2 : 1);
        set_req(port, 1'b0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 8; i++) mem_words[i] = 32'hA0A0_0000 | i;
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(3);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks", 32'({p0_ack, p0_err, p1_ack, p1_err}), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Both ports hold requests: grants alternate 0,1,0,1, acks 3 cycles apart
        k = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'd0, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'd4, 32'h0);
        expect_resp(1'b0, 1'b0, 1'b1, 32'hA0A0_0000, k + 2);
        expect_resp(1'b1, 1'b0, 1'b1, 32'hA0A0_0001, k + 5);
        expect_resp(1'b0, 1'b0, 1'b1, 32'hA0A0_0000, k + 8);
        expect_resp(1'b1, 1'b0, 1'b1, 32'hA0A0_0001, k + 11);
        tick(1);
        check("tie_busy", 32'(busy), 32'd1);
        check("tie_first_gnt", 32'(gnt_id), 32'd0);
        tick(3);
        check("tie_second_gnt", 32'(gnt_id), 32'd1);
        tick(7);
        set_req(1'b0, 1'b0);
        set_req(1'b1, 1'b0);
        tick(1);

        // Store then load at word 8
        txn(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF, 32'h0, 1'b1);
        txn(1'b0, 1'b0, 32'd8, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Highest legal word address 16; a store leaves rdata unchanged
        txn(1'b0, 1'b1, 32'd16, 32'h0102_0304, 32'h0, 1'b1);
        check("store_keeps_rdata", p0_rdata, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'd16, 32'h0, 32'h0102_0304, 1'b1);

        // Rejections: misaligned, beyond the last word, far out of range (store)
        txn(1'b1, 1'b0, 32'd6, 32'h0, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 32'd20, 32'h0, 32'h0, 1'b0);
        txn(1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'h0, 1'b0);
        check("mem_addr_hold", mem_addr, 32'd16);
        check("p1_rdata_after_err", p1_rdata, 32'hA0A0_0001);

        // p0 holds req through its ack while p1 waits: p1 wins next, then p0 again
        k = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'd8, 32'h0);
        expect_resp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, k + 2);
        expect_resp(1'b1, 1'b0, 1'b1, 32'h0102_0304, k + 5);
        expect_resp(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, k + 8);
        tick(1);
        set_port(1'b1, 1'b1, 1'b0, 32'd16, 32'h0);
        tick(4);
        set_req(1'b1, 1'b0);
        tick(3);
        set_req(1'b0, 1'b0);
        tick(1);

        // Reset during the ACCESS cycle of a store: the strobe already reached memory
        k = cyc;
        set_port(1'b0, 1'b1, 1'b1, 32'd12, 32'h55AA_55AA);
        expect_wr(32'd12, 32'h55AA_55AA);
        tick(1);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0);
        tick(1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_rw", 32'(mem_rw), 32'd0);
        check("abort_gnt_id", 32'(gnt_id), 32'd0);
        check("abort_ack", 32'({p0_ack, p0_err}), 32'd0);
        tick(1);
        rst_n = 1'b1;

        // First tie after reset goes to port 0
        k = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'd12, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'd0, 32'h0);
        expect_resp(1'b0, 1'b0, 1'b1, 32'h55AA_55AA, k + 2);
        expect_resp(1'b1, 1'b0, 1'b1, 32'hA0A0_0000, k + 5);
        tick(2);
        set_req(1'b0, 1'b0);
        tick(3);
        set_req(1'b1, 1'b0);
        tick(3);

        check("pending_resp", exp_q.size(), 32'd0);
        check("pending_wr", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
